// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, forward-select encodings and
// the per-stage shadow record used by the hazard scheduler.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       writes;
    logic       is_load;
    logic [4:0] src_a;
    logic [4:0] src_b;
  } shadow_t;

  // $0 is hard-wired, so it can never be the subject of a hazard or forward.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// D-stage inputs and stall/flush/forward outputs of the hazard scheduler.
interface hazard_sched_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             branch_taken_d;
  logic             hold;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             fwd_a_br;
  logic             fwd_b_br;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_d, valid_d, branch_taken_d, hold,
    input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           fwd_a_br, fwd_b_br, stall_count
  );

  modport slave (
    input  instr_d, valid_d, branch_taken_d, hold,
    output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e,
           fwd_a_br, fwd_b_br, stall_count
  );
endinterface

// File: rtl/instr_fields.sv
// Combinational decode of an instruction into its register-usage record.
module instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output shadow_t     fields,
  output logic        is_beq
);

  logic [5:0] op;
  logic [4:0] rs, rt, rd;
  logic       unused_low;

  assign op         = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign unused_low = ^instr[10:0];

  // Unused source/destination fields stay 0 so $0 suppresses every match.
  always_comb begin
    fields       = '0;
    fields.valid = valid;
    is_beq       = 1'b0;
    if (valid) begin
      case (op)
        OP_RTYPE: begin
          fields.src_a  = rs;
          fields.src_b  = rt;
          fields.dst    = rd;
          fields.writes = (rd != 5'd0);
        end
        OP_LW: begin
          fields.src_a   = rs;
          fields.dst     = rt;
          fields.writes  = (rt != 5'd0);
          fields.is_load = 1'b1;
        end
        OP_SW: begin
          fields.src_a = rs;
          fields.src_b = rt;
        end
        OP_BEQ: begin
          fields.src_a = rs;
          fields.src_b = rt;
          is_beq       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS pipeline: shadows E/M/W register
// usage and drives stall, flush and forward selects for the datapath.
module hazard_sched
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_sched_if.slave hs
);

  shadow_t          d_f;
  logic             beq_d;
  shadow_t          e_p0, m_p1, w_p2;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use, br_stall, stall;
  logic             m_fwd;
  logic             unused_fields;

  instr_fields u_dec (
    .instr  (hs.instr_d),
    .valid  (hs.valid_d),
    .fields (d_f),
    .is_beq (beq_d)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input shadow_t m, input shadow_t w);
    if (m.valid && m.writes && !m.is_load && reg_match(src, m.dst)) return FWD_EXM;
    if (w.valid && w.writes && reg_match(src, w.dst)) return FWD_MWB;
    return FWD_RF;
  endfunction

  assign unused_fields = ^{m_p1.src_a, m_p1.src_b, w_p2.src_a, w_p2.src_b, w_p2.is_load};

  always_comb begin
    m_fwd    = m_p1.valid & m_p1.writes & ~m_p1.is_load;
    load_use = e_p0.valid & e_p0.is_load & e_p0.writes &
               (reg_match(d_f.src_a, e_p0.dst) | reg_match(d_f.src_b, e_p0.dst));
    // beq compares in D, so it must also wait out a load sitting in M.
    br_stall = beq_d &
               ((e_p0.valid & e_p0.writes &
                 (reg_match(d_f.src_a, e_p0.dst) | reg_match(d_f.src_b, e_p0.dst))) |
                (m_p1.valid & m_p1.is_load & m_p1.writes &
                 (reg_match(d_f.src_a, m_p1.dst) | reg_match(d_f.src_b, m_p1.dst))));
    stall    = load_use | br_stall;
  end

  always_comb begin
    hs.stall_f  = 1'b0;
    hs.stall_d  = 1'b0;
    hs.flush_d  = 1'b0;
    hs.flush_e  = 1'b0;
    hs.fwd_a_e  = FWD_RF;
    hs.fwd_b_e  = FWD_RF;
    hs.fwd_a_br = 1'b0;
    hs.fwd_b_br = 1'b0;
    if (!rst) begin
      hs.stall_f  = hs.hold | stall;
      hs.stall_d  = hs.hold | stall;
      hs.flush_e  = ~hs.hold & stall;
      hs.flush_d  = ~hs.hold & ~stall & hs.branch_taken_d;
      if (e_p0.valid) begin
        hs.fwd_a_e = fwd_sel(e_p0.src_a, m_p1, w_p2);
        hs.fwd_b_e = fwd_sel(e_p0.src_b, m_p1, w_p2);
      end
      hs.fwd_a_br = beq_d & m_fwd & reg_match(d_f.src_a, m_p1.dst);
      hs.fwd_b_br = beq_d & m_fwd & reg_match(d_f.src_b, m_p1.dst);
    end
  end

  assign hs.stall_count = rst ? '0 : cnt_q;

  // D -> E (p0) -> M (p1) -> W (p2)
  always_ff @(posedge clk) begin
    if (rst) begin
      e_p0.valid <= 1'b0;
      m_p1.valid <= 1'b0;
      w_p2.valid <= 1'b0;
      cnt_q      <= '0;
    end else if (!hs.hold) begin
      w_p2 <= m_p1;
      m_p1 <= e_p0;
      e_p0 <= stall ? '0 : d_f;
      if (stall) cnt_q <= sat_inc(cnt_q);
    end
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Sequential hazard scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks register destinations of in-flight E/M/W instructions in its own shadow pipeline.
- Issues fetch/decode stalls, E/D flushes, a load-use bubble, E-stage forward selects and D-stage branch-compare forward selects.
- Sits beside the datapath; the datapath pipeline registers obey its stall/flush outputs.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- instr_d  in  32  instruction currently in D.
- valid_d  in  1  instr_d is a real instruction; 0 means bubble.
- branch_taken_d  in  1  beq in D resolved taken this cycle.
- hold  in  1  external freeze, e.g. memory wait.
- stall_f  out  1  hold PC / IF-ID.
- stall_d  out  1  hold ID-EX input side.
- flush_d  out  1  clear IF/ID.
- flush_e  out  1  insert bubble into ID/EX.
- fwd_a_e  out  2  E operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- fwd_b_e  out  2  E operand B source: same encoding as fwd_a_e.
- fwd_a_br  out  1  D beq rs from EX/MEM ALU result.
- fwd_b_br  out  1  D beq rt from EX/MEM ALU result.
- stall_count  out  CNT_W  cycles with load-use or branch stall, saturating.

Behaviour:
- Decode of instr_d, also applied to shadow entries:
  - R-type 000000: src rs, rt; dst rd.
  - lw 100011: src rs; dst rt; is_load.
  - sw 101011: src rs, rt; no dst.
  - beq 000100: src rs, rt; no dst.
  - Other opcodes, or valid_d=0: no src, no dst.
  - Register $0 never produces a hazard or forward.
- Shadow stages E, M, W each hold {valid, dst[4:0], writes, is_load, srcA[4:0], srcB[4:0]}.
- All outputs are combinational from instr_d and the shadow regs. Shadow regs and counter update on posedge clk.
- Load-use stall: a D src matches E.dst while E.is_load.
- Branch stall: D is beq and either:
  - a src matches E.dst while E.writes, or
  - a src matches M.dst while M.is_load.
- stall = load-use OR branch stall. When stall and hold=0:
  - stall_f = stall_d = 1, flush_e = 1.
  - Next cycle E <= bubble (valid=0).
- hold=1 overrides everything:
  - stall_f = stall_d = 1; flush_d = flush_e = 0.
  - Shadow regs frozen; stall_count unchanged.
- flush_d = branch_taken_d & ~stall & ~hold. branch_taken_d is ignored while stalled.
- Normal advance (no stall, no hold): W<=M, M<=E, E<=decode(instr_d, valid_d).
- E forward select, per operand, priority M over W:
  - 01 if E.src == M.dst, M.writes, and not M.is_load.
  - else 10 if E.src == W.dst and W.writes.
  - else 00.
- E.src matching an M load is unreachable because of the bubble; the bench asserts it never occurs.
- fwd_x_br = 1 when the D beq src matches M.dst, M.writes, and not M.is_load.
- stall_count increments on each cycle with stall=1 and hold=0; saturates at all-ones.
- Reset, synchronous:
  - All shadow valids = 0; stall_count = 0.
  - While rst=1, all outputs are forced 0.
  - Reset mid-stall drops the stall in the same cycle.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - forward encodings FWD_RF, FWD_EXM, FWD_MWB.
  - shadow-stage struct type.
- Sub-module instr_fields: combinational decode of opcode into src/dst/writes/is_load. Instantiated for D; its result is stored in the shadow regs.

Test Plan:
- Load-use stall: lw $2,0($1) then add $3,$2,$4 in D.
  - One cycle of stall_f=stall_d=flush_e=1.
  - Next cycle the add is in E with fwd_a_e=10; stall_count=1.
- Back-to-back ALU forwarding: add $5,$1,$1; sub $6,$5,$5.
  - sub in E: fwd_a_e=fwd_b_e=01, no stall.
  - Insert a nop between them: fwd=10.
- Branch stall then forward: add $7,.. followed by beq $7,$0.
  - One stall cycle.
  - Then fwd_a_br=1; branch_taken_d=1 gives flush_d=1.
  - A lw to $7 instead gives 2 stall cycles.
- Register $0: add $0,$1,$1; add $2,$0,$0 -> fwd 00, no stall.
- hold asserted 3 cycles during a load-use stall:
  - Outputs stalled, flush_e=0, stall_count frozen.
  - After release the load-use stall completes exactly once.
- rst asserted during a stall:
  - Outputs 0 in that cycle; shadow cleared.
  - The following add sees fwd 00; stall_count=0.
  - Saturation check with CNT_W=2: 5 stalls -> stall_count=3.
